// File: rtl/control_unit_if.sv
// Control/status bundle between control_unit and its y/s data path.
// The master side is the controller; the slave side is the data path.
interface control_unit_if;
  logic       start;
  logic       b;
  logic       y_inc;
  logic [1:0] y_select_next;
  logic [1:0] s_step;
  logic       y_en;
  logic       s_en;
  logic       y_store_x;
  logic       s_add;
  logic       s_zero;
  logic       busy;
  logic       done;

  modport master (
    input  start, b, y_inc,
    output y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero, busy, done
  );

  modport slave (
    output start, b, y_inc,
    input  y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero, busy, done
  );
endinterface

// File: rtl/control_unit.sv
// Sequencer for one load/scan pass over the 8 bit positions of y.
// The pass is LOAD, then SCAN for 8 cycles, then a one-cycle DONE pulse.
module control_unit (
  input  logic                 clk,
  input  logic                 rst,
  control_unit_if.master       cu
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cu.y_select_next = '0;
    cu.s_step        = '0;
    cu.y_en          = 1'b0;
    cu.s_en          = 1'b0;
    cu.y_store_x     = 1'b0;
    cu.s_add         = 1'b0;
    cu.s_zero        = 1'b0;
    cu.busy          = 1'b0;
    cu.done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cu.start) state_d = LOAD;
      end

      LOAD: begin
        cu.y_store_x = 1'b1;
        cu.y_en      = 1'b1;
        cu.s_zero    = 1'b1;
        cu.s_add     = 1'b1;
        cu.s_step    = 2'd0;
        cu.s_en      = 1'b1;
        cu.busy      = 1'b1;
        idx_d        = '0;
        state_d      = SCAN;
      end

      SCAN: begin
        cu.s_add  = 1'b1;
        cu.s_step = 2'd1;
        cu.s_en   = 1'b1;
        cu.busy   = 1'b1;
        idx_d     = idx_q + 3'd1;
        // Mealy y update: selected bit outranks the s==1 increment
        if (cu.b) begin
          cu.y_select_next = 2'd2;
          cu.y_en          = 1'b1;
        end else if (cu.y_inc) begin
          cu.y_select_next = 2'd1;
          cu.y_en          = 1'b1;
        end
        if (idx_q == 3'd7) state_d = DONE;
      end

      DONE: begin
        cu.done = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Rising-edge clock shared with the data path.
REQ-003 rst  input  1  Asynchronous active-low reset; 0 forces the reset state immediately.
REQ-004 start  input  1  Request to run one pass on the current x; sampled only in IDLE.
REQ-005 b  input  1  Status from the data path: selected bit y[s].
REQ-006 y_inc  input  1  Status from the data path: 1 when s == 1.
REQ-007 y_select_next  output  2  Data-path y source: 0 = hold, 1 = y+1, 2 = y+s, 3 = y-s.
REQ-008 s_step  output  2  Data-path s step amount.
REQ-009 y_en, s_en  output  1 each  Data-path register enables.
REQ-010 y_store_x  output  1  Data-path load select: y <= x.
REQ-011 s_add  output  1  Data-path s direction: 1 = add, 0 = subtract.
REQ-012 s_zero  output  1  Data-path s base: 1 forces the base to 0.
REQ-013 busy  output  1  High while a pass is in progress (LOAD or SCAN).
REQ-014 done  output  1  One-cycle pulse when a pass completes.

Function
REQ-015 The states SHALL be IDLE, LOAD, SCAN and DONE, plus an internal 3-bit index counter idx that mirrors data-path s.
REQ-016 Every control output SHALL default to 0 in every state unless a requirement below sets it.
REQ-017 IDLE: if start = 1, go to LOAD; otherwise stay in IDLE.
REQ-018 LOAD outputs SHALL be: y_store_x = 1, y_en = 1, s_zero = 1, s_add = 1, s_step = 0, s_en = 1.
  - Effect: y <= x and s <= 0 at the clock edge.
  - Also: idx <= 0; next state SCAN.
REQ-019 SCAN, s-update outputs SHALL always be: s_add = 1, s_step = 1, s_en = 1; idx <= idx + 1.
REQ-020 SCAN, y-update outputs SHALL be combinational from the current b and y_inc (Mealy), with priority:
  - b = 1: y_select_next = 2, y_en = 1.
  - else y_inc = 1: y_select_next = 1, y_en = 1.
  - else: y_select_next = 0, y_en = 0.
REQ-021 SCAN SHALL last exactly 8 cycles; the cycle with idx = 7 transitions to DONE, so s wraps from 7 to 0.
REQ-022 DONE: done = 1 for exactly one cycle, no register enables, next state IDLE.
REQ-023 Latency SHALL be fixed at 10 cycles from the start-sampling edge to the done pulse (LOAD 1, SCAN 8, DONE 1).
REQ-024 start SHALL be ignored in LOAD, SCAN and DONE; a start held high in DONE begins a new pass only after returning to IDLE.
REQ-025 busy SHALL equal 1 exactly in LOAD and SCAN.
REQ-026 idx arithmetic SHALL be modulo 8.

Reset
REQ-027 While rst = 0, the state SHALL be IDLE and idx = 0.
  - Every output is 0, including done and busy.
  - This holds even mid-pass, asynchronously, without waiting for a clock edge.
REQ-028 After rst deasserts, the block SHALL take no action until start is sampled high in IDLE.

Verification
REQ-029 The bench SHALL connect the block to the data path, drive the data path's active-high reset from the inverted rst, and check y when done is 1:
  - x = 8'h00, start pulse -> done 10 cycles later; y = 8'h01 (only the y_inc step fires, at s = 1).
  - x = 8'h04 -> at s = 1, y_inc gives y = 8'h05; at s = 2, b gives y = 8'h07; final y = 8'h07.
  - x = 8'h80 -> y = 8'h81 after s = 1; at s = 7, b = 1 gives y = 8'h88; final y = 8'h88, s = 0.
  - start held high continuously -> passes repeat every 11 cycles; exactly one done pulse per pass; busy low in DONE and IDLE.
  - rst = 0 during SCAN with idx = 4 -> all outputs 0 immediately; after release with start = 0, state stays IDLE and no enables assert.
  - start = 1 in SCAN or DONE -> no extra LOAD; pass length remains 10 cycles.
